mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit in the E stage of the five-stage pipeline, alongside the ALU. Accepts mult/multu/div/divu (and optionally madd/maddu) from the E stage, holds HI/LO, and raises `busy` so hazard logic stalls the D stage. The E stage sends HI/LO to the E→M pipeline register for mfhi/mflo, and that register then carries them toward writeback.

## Interface
Parameters:
- `MULT_CYCLES`, 5: cycles `busy` stays high after a multiply start.
- `DIV_CYCLES`, 10: cycles `busy` stays high after a divide start.

Ports:
- `clk`  input  1  sole clock, rising-edge.
- `reset`  input  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  input  1  one-cycle pulse; E-stage instruction is a mult/div-class op.
- `op`  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu; others reserved.
- `A`  input  32  forwarded rs value.
- `B`  input  32  forwarded rt value.
- `hi_we`  input  1  mthi: HI <= A.
- `lo_we`  input  1  mtlo: LO <= A.
- `busy`  output  1  operation in flight.
- `HI`  output  32  HI register.
- `LO`  output  32  LO register.

## Operation
- States: IDLE, RUN. Down-counter `cnt` is 4 bits wide, which is enough for `DIV_CYCLES` ≤ 15. Result registers `hi_tmp` and `lo_tmp` are each 32 bits.
- IDLE + `start` + legal op: compute the result from the `A`/`B` values sampled at that edge into `hi_tmp`/`lo_tmp`. Load `cnt` with N−1, where N is `MULT_CYCLES` or `DIV_CYCLES`. Go to RUN. HI/LO stay unchanged.
- RUN: decrement `cnt` each edge. At the edge where `cnt`==0, commit HI<=`hi_tmp`, LO<=`lo_tmp` and return to IDLE.
- `busy` = (state==RUN). It is registered and has no combinational path from `start`. Hazard logic stalls on `start | busy` when the D-stage instruction is a mult/div/mfhi/mflo/mthi/mtlo.
- mult: signed 32×32 product, 64-bit result. {HI,LO} = product.
- multu: unsigned 32×32 product, 64-bit result. {HI,LO} = product.
- div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (`B`==0): the full `DIV_CYCLES` still elapse, then HI/LO are left unchanged.
- `hi_we`/`lo_we` write in IDLE only. They take effect on the next edge.
- Boundary rules:
  - `start` during RUN: ignored.
  - `hi_we`/`lo_we` during RUN: ignored.
  - `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
  - Reserved or disabled op with `start`: no-op; `busy` stays 0.
- Reset (including mid-RUN): state=IDLE, `busy`=0, `cnt`=0, HI=0, LO=0, `hi_tmp`=`lo_tmp`=0. Any pending result is discarded.

## Timing
- `start` sampled at edge t0, so `busy` is 1 from just after t0.
- HI/LO take the new value at edge t0+N, and `busy` falls at that same edge.
- Total `busy` duration is N cycles: 5 for multiply, 10 for divide by default.
- mfhi/mflo in E during the cycle after t0+N read the new value.
- mthi/mtlo latency is 1 edge.
- HI/LO outputs come straight from registers, with no internal bypass from `hi_tmp`.

## Configuration
- `MDU_MADD_EN` defined: op 100 (madd) gives {HI,LO} <= {HI,LO} + signed(A)×signed(B). Op 101 (maddu) does the same with an unsigned product. Both use 64-bit wrap-around addition, `MULT_CYCLES` latency, and the HI/LO values present at t0.
- `MDU_MADD_EN` undefined: ops 100/101 are reserved, so `start` is ignored and no accumulator adder is synthesized.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with A=0xFFFFFFF9 (−7), B=2 → `busy` high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=0 → HI/LO unchanged after 10 cycles.
- mthi with A=0x12345678, then start div; during RUN pulse `lo_we` and `start` → both ignored, final HI/LO equal the div result.
- Assert `reset` at cycle 4 of a div → next edge `busy`=0, HI=LO=0, and no later commit occurs.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → HI=1, LO=0. Without `MDU_MADD_EN`: the same stimulus leaves `busy`=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the HI/LO registers
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, op, A, B : launch mult/multu/div/divu (madd/maddu when MDU_MADD_EN)
//   hi_we, lo_we    : mthi/mtlo, HI or LO <= A when idle
//   busy            : operation in flight (registered)
//   HI, LO          : architectural result registers
// Optional feature: define MDU_MADD_EN to enable madd/maddu (ops 100/101).
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hi_we,
   input  logic        lo_we,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES - 1);
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] hi_q, lo_q, hi_tmp_q, lo_tmp_q, hi_tmp_d, lo_tmp_d;
   logic        is_div, sgn, legal;
   logic [63:0] ma, mb, prod;
   logic [31:0] a_abs, b_abs, quo, rem;
   always_comb begin
      is_div = op[1];
      sgn    = ~op[0];
`ifdef MDU_MADD_EN
      legal  = ~op[2] | ~op[1];
`else
      legal  = ~op[2];
`endif
      // Low 64 bits of a 64x64 product of the extended operands give both signed and unsigned results
      ma    = sgn ? {{32{A[31]}}, A} : {32'b0, A};
      mb    = sgn ? {{32{B[31]}}, B} : {32'b0, B};
      prod  = ma * mb;
      // Divide on magnitudes, then restore signs: quotient by sign mismatch, remainder follows dividend
      a_abs = (sgn & A[31]) ? -A : A;
      b_abs = (sgn & B[31]) ? -B : B;
      quo   = (b_abs == '0) ? '0 : a_abs / b_abs;
      rem   = (b_abs == '0) ? '0 : a_abs % b_abs;
      {hi_tmp_d, lo_tmp_d} = prod;
`ifdef MDU_MADD_EN
      if (op[2]) {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} + prod;
`endif
      // Divide by zero reloads the current HI/LO so the commit leaves them unchanged
      if (is_div) {hi_tmp_d, lo_tmp_d} = (B == '0) ? {hi_q, lo_q} :
         {(sgn & A[31]) ? -rem : rem, (sgn & (A[31] ^ B[31])) ? -quo : quo};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         hi_tmp_q <= '0;
         lo_tmp_q <= '0;
      end else if (state_q == IDLE) begin
         if (start & legal) begin
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            cnt_q    <= is_div ? DIV_N : MULT_N;
            state_q  <= RUN;
         end else if (!start) begin
            if (hi_we) hi_q <= A;
            if (lo_we) lo_q <= A;
         end
      end else if (cnt_q == '0) begin
         hi_q    <= hi_tmp_q;
         lo_q    <= lo_tmp_q;
         state_q <= IDLE;
      end else begin
         cnt_q <= cnt_q - 4'd1;
      end
   end
   assign busy = (state_q == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with a behavioural HI/LO model
module tb_mult_div_unit;
   localparam int MC = 5;
   localparam int DC = 10;
   logic        clk = 1'b0;
   logic        reset, start, hi_we, lo_we, busy;
   logic [2:0]  op;
   logic [31:0] A, B, HI, LO;
   typedef struct {logic [31:0] hi; logic [31:0] lo; int n;} exp_t;
   exp_t        sbq[$];
   int          passed = 0;
   int          total = 0;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;
   always #5 clk = ~clk;
   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .HI(HI), .LO(LO)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output bit lg, output int n, output logic [31:0] hi, output logic [31:0] lo);
      hi = mhi;
      lo = mlo;
      lg = 1'b1;
      n  = MC;
      case (o)
         3'd0: {hi, lo} = longint'(signed'(a)) * longint'(signed'(b));
         3'd1: {hi, lo} = 64'(a) * 64'(b);
         3'd2, 3'd3: begin
            n = DC;
            if (b != 0) begin
               if (o == 3'd3) begin
                  lo = a / b;
                  hi = a % b;
               end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                  lo = a;
                  hi = '0;
               end else begin
                  lo = 32'(signed'(a) / signed'(b));
                  hi = 32'(signed'(a) % signed'(b));
               end
            end
         end
`ifdef MDU_MADD_EN
         3'd4: {hi, lo} = {mhi, mlo} + 64'(longint'(signed'(a)) * longint'(signed'(b)));
         3'd5: {hi, lo} = {mhi, mlo} + 64'(a) * 64'(b);
`endif
         default: lg = 1'b0;
      endcase
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bit lg;
      int n;
      logic [31:0] h, l;
      model(o, a, b, lg, n, h, l);
      if (lg) begin
         sbq.push_back('{hi: h, lo: l, n: n});
         mhi = h;
         mlo = l;
      end
      op = o;
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (!lg) chk("reserved_busy", {31'b0, busy}, 32'd0);
   endtask
   task automatic wait_idle;
      for (int i = 0; i < 40 && busy; i++) tick();
      chk("busy_timeout", {31'b0, busy}, 32'd0);
   endtask
   task automatic wr(input bit h, input bit l, input logic [31:0] a);
      hi_we = h;
      lo_we = l;
      A = a;
      tick();
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (h) mhi = a;
      if (l) mlo = a;
      chk("mt_HI", HI, mhi);
      chk("mt_LO", LO, mlo);
   endtask
   // Monitor: each busy fall is a commit; compare run length and HI/LO with the oldest expectation
   initial begin
      int len;
      bit prev;
      exp_t e;
      len = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            len = 0;
            prev = 1'b0;
         end else begin
            if (busy) len++;
            else if (prev) begin
               if (sbq.size() == 0) begin
                  total++;
                  $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit", HI, LO);
               end else begin
                  e = sbq.pop_front();
                  chk("busy_len", 32'(len), 32'(e.n));
                  chk("HI", HI, e.hi);
                  chk("LO", LO, e.lo);
               end
               len = 0;
            end
            prev = busy;
         end
      end
   end
   initial begin
      logic [2:0]  o;
      logic [31:0] a, b;
      reset = 1'b1;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      op = '0;
      A = '0;
      B = '0;
      repeat (3) tick();
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_HI", HI, 32'd0);
      chk("reset_LO", LO, 32'd0);
      reset = 1'b0;
      tick();
      issue(3'd0, 32'hFFFFFFFE, 32'd3);
      wait_idle();
      issue(3'd1, 32'hFFFFFFFF, 32'd2);
      wait_idle();
      issue(3'd2, 32'hFFFFFFF9, 32'd2);
      wait_idle();
      wr(1'b0, 1'b1, 32'h00000055);
      issue(3'd3, 32'd7, 32'd0);
      wait_idle();
      // mthi then a divide; start and mtlo pulsed mid-run must be ignored
      wr(1'b1, 1'b0, 32'h12345678);
      issue(3'd2, 32'd1000, 32'd7);
      tick();
      lo_we = 1'b1;
      start = 1'b1;
      op = 3'd0;
      A = 32'hDEADBEEF;
      B = 32'd9;
      tick();
      lo_we = 1'b0;
      start = 1'b0;
      wait_idle();
      // start beats a simultaneous mthi
      hi_we = 1'b1;
      issue(3'd0, 32'h00010000, 32'h00010000);
      hi_we = 1'b0;
      wait_idle();
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_idle();
      issue(3'd2, 32'h80000007, 32'd5);
      wait_idle();
      // madd accumulator carry (no-op when the feature is disabled)
      wr(1'b1, 1'b0, 32'd0);
      wr(1'b0, 1'b1, 32'hFFFFFFFF);
      issue(3'd5, 32'd1, 32'd1);
      wait_idle();
      tick();
      chk("maddu_HI", HI, mhi);
      chk("maddu_LO", LO, mlo);
      issue(3'd6, 32'd5, 32'd6);
      issue(3'd7, 32'd5, 32'd6);
      chk("reserved_HI", HI, mhi);
      chk("reserved_LO", LO, mlo);
      repeat (40) begin
         if ($urandom_range(0, 9) < 2) begin
            wr(1'($urandom), 1'($urandom), $urandom);
         end else begin
`ifdef MDU_MADD_EN
            o = 3'($urandom_range(0, 5));
`else
            o = 3'($urandom_range(0, 3));
`endif
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
               a = 32'h80000000;
               b = 32'hFFFFFFFF;
            end
            issue(o, a, b);
            wait_idle();
         end
      end
      // reset on the fourth edge of a divide discards the pending result
      issue(3'd2, 32'd100, 32'd3);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("rst_run_busy", {31'b0, busy}, 32'd0);
      chk("rst_run_HI", HI, 32'd0);
      chk("rst_run_LO", LO, 32'd0);
      sbq.delete();
      mhi = '0;
      mlo = '0;
      tick();
      reset = 1'b0;
      repeat (15) tick();
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
      chk("post_rst_HI", HI, 32'd0);
      chk("post_rst_LO", LO, 32'd0);
      tick();
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
